// File: rtl/dma_job_scheduler.sv
// Round-robin scheduler that shares one dma engine between NUM_CH copy requesters.
// Each job issues a paired read/write command, waits for both completions, and is guarded by a watchdog.
module dma_job_scheduler #(
    parameter int NUM_CH         = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TOP_LEN_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_WIDTH       = 16,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH-1:0]                  ch_req_valid,
    output logic [NUM_CH-1:0]                  ch_req_ready,
    input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]   ch_src_addr,
    input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]   ch_dst_addr,
    input  logic [NUM_CH*TOP_LEN_WIDTH-1:0]    ch_len,
    output logic [NUM_CH-1:0]                  ch_done,
    output logic [NUM_CH-1:0]                  ch_err,
    output logic                               read_start,
    output logic                               top_read_valid,
    output logic [AXI_ADDR_WIDTH-1:0]          top_read_addr,
    output logic [TOP_LEN_WIDTH-1:0]           top_read_len,
    input  logic                               read_done,
    output logic                               write_start,
    output logic                               top_write_valid,
    output logic [AXI_ADDR_WIDTH-1:0]          top_write_addr,
    output logic [TOP_LEN_WIDTH-1:0]           top_write_len,
    input  logic                               write_done,
    input  logic                               err_clear,
    output logic                               busy,
    output logic [CH_W-1:0]                    active_ch
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

    localparam logic [TO_WIDTH-1:0] WD_LAST =
        TO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t                     state_reg;
    logic [CH_W-1:0]            rr_ptr_reg;
    logic                       rd_seen_reg;
    logic                       wr_seen_reg;
    logic [TO_WIDTH-1:0]        wd_reg;

    logic [AXI_ADDR_WIDTH-1:0]  src_arr [NUM_CH];
    logic [AXI_ADDR_WIDTH-1:0]  dst_arr [NUM_CH];
    logic [TOP_LEN_WIDTH-1:0]   len_arr [NUM_CH];

    logic                       grant_found;
    logic [CH_W-1:0]            grant_idx;
    logic [CH_W-1:0]            rr_ptr_next;
    logic                       rd_all;
    logic                       wr_all;
    logic                       job_complete;
    logic                       wd_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign src_arr[gi] = ch_src_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            assign dst_arr[gi] = ch_dst_addr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            assign len_arr[gi] = ch_len[gi*TOP_LEN_WIDTH +: TOP_LEN_WIDTH];
        end
    endgenerate

    // First valid channel at or above rr_ptr, wrapping around.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr_reg) + i) % NUM_CH;
            if (!grant_found && ch_req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    assign rr_ptr_next = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);

    // Gated by rst_n so the handshake is also silent while reset is held.
    always_comb begin
        ch_req_ready = '0;
        if (rst_n && state_reg == IDLE && grant_found)
            ch_req_ready[grant_idx] = 1'b1;
    end

    assign rd_all       = rd_seen_reg | read_done;
    assign wr_all       = wr_seen_reg | write_done;
    assign job_complete = rd_all & wr_all;
    assign wd_expired   = (TIMEOUT_CYCLES != 0) && (wd_reg == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            rd_seen_reg     <= 1'b0;
            wr_seen_reg     <= 1'b0;
            wd_reg          <= '0;
            ch_done         <= '0;
            ch_err          <= '0;
            read_start      <= 1'b0;
            top_read_valid  <= 1'b0;
            top_read_addr   <= '0;
            top_read_len    <= '0;
            write_start     <= 1'b0;
            top_write_valid <= 1'b0;
            top_write_addr  <= '0;
            top_write_len   <= '0;
            busy            <= 1'b0;
            active_ch       <= '0;
        end else begin
            ch_done         <= '0;
            ch_err          <= '0;
            read_start      <= 1'b0;
            top_read_valid  <= 1'b0;
            write_start     <= 1'b0;
            top_write_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        rr_ptr_reg     <= rr_ptr_next;
                        active_ch      <= grant_idx;
                        top_read_addr  <= src_arr[grant_idx];
                        top_write_addr <= dst_arr[grant_idx];
                        top_read_len   <= len_arr[grant_idx];
                        top_write_len  <= len_arr[grant_idx];
                        if (len_arr[grant_idx] != '0) begin
                            read_start      <= 1'b1;
                            top_read_valid  <= 1'b1;
                            write_start     <= 1'b1;
                            top_write_valid <= 1'b1;
                            busy            <= 1'b1;
                            state_reg       <= ISSUE;
                        end else begin
                            // Nothing to move: complete without touching the dma.
                            ch_done[grant_idx] <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    rd_seen_reg <= 1'b0;
                    wr_seen_reg <= 1'b0;
                    wd_reg      <= '0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    // Completion is tested first so it beats a same-cycle timeout.
                    if (job_complete) begin
                        ch_done[active_ch] <= 1'b1;
                        rd_seen_reg        <= 1'b0;
                        wr_seen_reg        <= 1'b0;
                        wd_reg             <= '0;
                        busy               <= 1'b0;
                        state_reg          <= IDLE;
                    end else if (wd_expired) begin
                        ch_err[active_ch] <= 1'b1;
                        state_reg         <= ERR;
                    end else begin
                        rd_seen_reg <= rd_all;
                        wr_seen_reg <= wr_all;
                        wd_reg      <= wd_reg + TO_WIDTH'(1);
                    end
                end
                ERR: begin
                    if (err_clear) begin
                        rd_seen_reg <= 1'b0;
                        wr_seen_reg <= 1'b0;
                        wd_reg      <= '0;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Directed bench for dma_job_scheduler: table of arbitration/job vectors plus
// hand sequences for spurious dones, watchdog timeout, completion/timeout race and mid-job reset.
module tb_dma_job_scheduler;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int TO  = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    ch_req_valid = '0;
    logic [NCH-1:0]    ch_req_ready;
    logic [NCH*AW-1:0] ch_src_addr = '0;
    logic [NCH*AW-1:0] ch_dst_addr = '0;
    logic [NCH*LW-1:0] ch_len = '0;
    logic [NCH-1:0]    ch_done;
    logic [NCH-1:0]    ch_err;
    logic              read_start, top_read_valid, write_start, top_write_valid;
    logic [AW-1:0]     top_read_addr, top_write_addr;
    logic [LW-1:0]     top_read_len, top_write_len;
    logic              read_done = 1'b0;
    logic              write_done = 1'b0;
    logic              err_clear = 1'b0;
    logic              busy;
    logic [1:0]        active_ch;

    int checks = 0;
    int errors = 0;

    dma_job_scheduler #(
        .NUM_CH(NCH), .AXI_ADDR_WIDTH(AW), .TOP_LEN_WIDTH(LW),
        .TIMEOUT_CYCLES(TO), .TO_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_src_addr(ch_src_addr), .ch_dst_addr(ch_dst_addr), .ch_len(ch_len),
        .ch_done(ch_done), .ch_err(ch_err),
        .read_start(read_start), .top_read_valid(top_read_valid),
        .top_read_addr(top_read_addr), .top_read_len(top_read_len),
        .read_done(read_done),
        .write_start(write_start), .top_write_valid(top_write_valid),
        .top_write_addr(top_write_addr), .top_write_len(top_write_len),
        .write_done(write_done),
        .err_clear(err_clear), .busy(busy), .active_ch(active_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] len;
        logic [3:0]  exp_ready;
        int          exp_ch;
        int          rd_dly;
        int          wr_dly;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len_all(input logic [31:0] len);
        for (int i = 0; i < NCH; i++) ch_len[i*LW +: LW] = len;
    endtask

    // Waits from the first WAIT cycle until both dones have been delivered.
    task automatic finish_job(input int ch, input int rd_dly, input int wr_dly);
        int last;
        last = (rd_dly > wr_dly) ? rd_dly : wr_dly;
        for (int c = 1; c <= last; c++) begin
            read_done  = (c == rd_dly);
            write_done = (c == wr_dly);
            step();
            read_done  = 1'b0;
            write_done = 1'b0;
            if (c == last - 1) check("done_early", 64'(ch_done), 64'd0);
        end
        check("done_pulse", 64'(ch_done), 64'(4'b0001 << ch));
        check("no_err", 64'(ch_err), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        step();
        check("done_single", 64'(ch_done), 64'd0);
    endtask

    task automatic run_job(input vec_t v);
        set_len_all(v.len);
        ch_req_valid = v.valid;
        #1;
        check("ready", 64'(ch_req_ready), 64'(v.exp_ready));
        step();
        ch_req_valid = '0;
        $display("job valid=%b len=%0d ready=%b active_ch=%0d", v.valid, v.len, v.exp_ready, active_ch);
        check("active_ch", 64'(active_ch), 64'(v.exp_ch));
        if (v.len == 0) begin
            check("zero_done", 64'(ch_done), 64'(4'b0001 << v.exp_ch));
            check("zero_no_read", 64'(read_start), 64'd0);
            check("zero_busy", 64'(busy), 64'd0);
            step();
            check("zero_done_single", 64'(ch_done), 64'd0);
        end else begin
            check("issue_strobes", 64'({read_start, top_read_valid, write_start, top_write_valid}), 64'hF);
            check("rd_addr", 64'(top_read_addr), 64'(32'h1000 + v.exp_ch * 32'h100));
            check("wr_addr", 64'(top_write_addr), 64'(32'h2000 + v.exp_ch * 32'h100));
            check("rd_len", 64'(top_read_len), 64'(v.len));
            check("wr_len", 64'(top_write_len), 64'(v.len));
            check("busy_issue", 64'(busy), 64'd1);
            step();
            check("strobes_drop", 64'({read_start, write_start}), 64'd0);
            finish_job(v.exp_ch, v.rd_dly, v.wr_dly);
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            ch_src_addr[i*AW +: AW] = 32'h1000 + i * 32'h100;
            ch_dst_addr[i*AW +: AW] = 32'h2000 + i * 32'h100;
        end
        vecs[0] = '{4'b1111, 32'd64, 4'b0001, 0, 10, 20};
        vecs[1] = '{4'b1111, 32'd16, 4'b0010, 1, 5, 5};
        vecs[2] = '{4'b1111, 32'd32, 4'b0100, 2, 7, 3};
        vecs[3] = '{4'b1111, 32'd8,  4'b1000, 3, 2, 2};
        vecs[4] = '{4'b1111, 32'd4,  4'b0001, 0, 1, 1};
        vecs[5] = '{4'b0101, 32'd0,  4'b0100, 2, 0, 0};
        vecs[6] = '{4'b1001, 32'd12, 4'b1000, 3, 4, 1};
        vecs[7] = '{4'b1010, 32'd20, 4'b0010, 1, 1, 6};
        vecs[8] = '{4'b0001, 32'd24, 4'b0001, 0, 3, 3};

        // Reset state
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", 64'({ch_done, ch_err, read_start, write_start, top_read_valid, top_write_valid}), 64'd0);
        check("rst_active", 64'(active_ch), 64'd0);
        check("rst_ready", 64'(ch_req_ready), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_job(vecs[i]);

        // Done pulses during ISSUE are ignored; rr_ptr now 1 -> ch1.
        set_len_all(32'd40);
        ch_req_valid = 4'b0010;
        step();
        ch_req_valid = '0;
        $display("job spurious-done test active_ch=%0d", active_ch);
        check("spur_active", 64'(active_ch), 64'd1);
        read_done = 1'b1; write_done = 1'b1;
        step();
        read_done = 1'b0; write_done = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            read_done  = (c == 3);
            write_done = (c == 7);
            step();
            read_done  = 1'b0;
            write_done = 1'b0;
            check("spur_done", 64'(ch_done), (c == 7) ? 64'h2 : 64'h0);
        end
        step();

        // Watchdog timeout on ch3 (rr_ptr 2, only ch3 valid).
        set_len_all(32'd48);
        ch_req_valid = 4'b1000;
        step();
        ch_req_valid = '0;
        $display("job timeout test active_ch=%0d", active_ch);
        check("to_active", 64'(active_ch), 64'd3);
        step();
        for (int c = 1; c <= TO; c++) begin
            step();
            if (c == TO - 1) check("to_early", 64'(ch_err), 64'd0);
        end
        check("to_err", 64'(ch_err), 64'h8);
        check("to_busy", 64'(busy), 64'd1);
        ch_req_valid = 4'b1111;
        read_done = 1'b1; write_done = 1'b1;
        step();
        read_done = 1'b0; write_done = 1'b0;
        check("err_single", 64'(ch_err), 64'd0);
        check("err_no_ready", 64'(ch_req_ready), 64'd0);
        check("err_ignore_done", 64'(ch_done), 64'd0);
        check("err_busy", 64'(busy), 64'd1);
        ch_req_valid = '0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("clear_busy", 64'(busy), 64'd0);
        run_job('{4'b1111, 32'd8, 4'b0001, 0, 2, 3});

        // Completion in the timeout cycle wins (rr_ptr 1, ch2 only).
        run_job('{4'b0100, 32'd16, 4'b0100, 2, 50, TO});

        // Async reset during WAIT, ch3 owns the job.
        set_len_all(32'd64);
        ch_req_valid = 4'b1111;
        step();
        $display("job reset test active_ch=%0d", active_ch);
        check("rstw_active", 64'(active_ch), 64'd3);
        ch_req_valid = '0;
        step();
        step();
        ch_req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_busy", 64'(busy), 64'd0);
        check("rstw_active0", 64'(active_ch), 64'd0);
        check("rstw_ready", 64'(ch_req_ready), 64'd0);
        check("rstw_addr", 64'(top_read_addr), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rstw_rr0", 64'(ch_req_ready), 64'h1);
        step();
        ch_req_valid = '0;
        check("rstw_regrant", 64'(active_ch), 64'd0);
        check("rstw_issue", 64'(read_start), 64'd1);
        step();
        finish_job(0, 2, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
